// File: rtl/ps2kbd_pkg.sv
// Shared scan-code constants and the set-2 to ASCII translation for the PS/2 keyboard receiver.
// Pure definitions: no latency, no flow control.
package ps2kbd_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  localparam int DEF_TIMEOUT_CYCLES = 5000;

  function automatic logic [7:0] scan_to_ascii(input logic [7:0] code, input logic shift);
    logic [15:0] pair;  // {unshifted, shifted}
    pair = 16'h0000;
    case (code)
      8'h1C: pair = "aA";  8'h32: pair = "bB";  8'h21: pair = "cC";  8'h23: pair = "dD";
      8'h24: pair = "eE";  8'h2B: pair = "fF";  8'h34: pair = "gG";  8'h33: pair = "hH";
      8'h43: pair = "iI";  8'h3B: pair = "jJ";  8'h42: pair = "kK";  8'h4B: pair = "lL";
      8'h3A: pair = "mM";  8'h31: pair = "nN";  8'h44: pair = "oO";  8'h4D: pair = "pP";
      8'h15: pair = "qQ";  8'h2D: pair = "rR";  8'h1B: pair = "sS";  8'h2C: pair = "tT";
      8'h3C: pair = "uU";  8'h2A: pair = "vV";  8'h1D: pair = "wW";  8'h22: pair = "xX";
      8'h35: pair = "yY";  8'h1A: pair = "zZ";
      8'h45: pair = 16'h3029;  8'h16: pair = 16'h3121;  8'h1E: pair = 16'h3240;
      8'h26: pair = 16'h3323;  8'h25: pair = 16'h3424;  8'h2E: pair = 16'h3525;
      8'h36: pair = 16'h365E;  8'h3D: pair = 16'h3726;  8'h3E: pair = 16'h382A;
      8'h46: pair = 16'h3928;
      8'h4E: pair = 16'h2D5F;  8'h55: pair = 16'h3D2B;  8'h41: pair = 16'h2C3C;
      8'h49: pair = 16'h2E3E;  8'h4A: pair = 16'h2F3F;  8'h4C: pair = 16'h3B3A;
      8'h52: pair = 16'h2722;  8'h54: pair = 16'h5B7B;  8'h5B: pair = 16'h5D7D;
      8'h5D: pair = 16'h5C7C;  8'h0E: pair = 16'h607E;
      8'h29: pair = 16'h2020;  8'h5A: pair = 16'h0D0D;  8'h66: pair = 16'h0808;
      8'h0D: pair = 16'h0909;  8'h76: pair = 16'h1B1B;
      default: pair = 16'h0000;
    endcase
    return shift ? pair[7:0] : pair[15:8];
  endfunction

endpackage

// File: rtl/ps2kbd_rx.sv
// PS/2 frame receiver: 2-flop sync, falling-edge sampling, parity/stop check, idle-bus timeout.
// byte_valid/frame_err pulse 1 cycle after the synced stop edge; no backpressure (keyboard cannot be stalled).
module ps2kbd_rx
  import ps2kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2clk,
  input  logic       ps2data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic          clk_s1, clk_s2, clk_prev;
  logic          dat_s1, dat_s2;
  logic [3:0]    bit_cnt;
  logic [8:0]    shreg;  // {parity, data[7:0]} once all nine bits are in
  logic [TW-1:0] to_cnt;
  logic          fall;

  assign fall = clk_prev & ~clk_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1     <= 1'b1;
      clk_s2     <= 1'b1;
      clk_prev   <= 1'b1;
      dat_s1     <= 1'b1;
      dat_s2     <= 1'b1;
      bit_cnt    <= 4'd0;
      shreg      <= 9'd0;
      to_cnt     <= '0;
      rx_byte    <= 8'h00;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      clk_s1     <= ps2clk;
      clk_s2     <= clk_s1;
      clk_prev   <= clk_s2;
      dat_s1     <= ps2data;
      dat_s2     <= dat_s1;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        to_cnt <= '0;
        if (bit_cnt == 4'd0) begin
          // a high start bit is treated as noise, not as an error
          if (!dat_s2) bit_cnt <= 4'd1;
        end else if (bit_cnt < 4'd10) begin
          shreg   <= {dat_s2, shreg[8:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end else begin
          bit_cnt <= 4'd0;
          if ((^shreg) && dat_s2) begin
            rx_byte    <= shreg[7:0];
            byte_valid <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
        end
      end else if (bit_cnt != 4'd0) begin
        if (to_cnt == TO_LAST) begin
          to_cnt    <= '0;
          bit_cnt   <= 4'd0;
          frame_err <= 1'b1;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ps2kbd.sv
// PS/2 set-2 keyboard to ASCII: make/break/extended decode with Shift tracking.
// ps2valid 2 cycles after the synced stop edge; ps2err passes straight from the receiver; no backpressure.
module ps2kbd
  import ps2kbd_pkg::*;
#(
  parameter int CLK_HZ         = 25000000,
  parameter int TIMEOUT_CYCLES = CLK_HZ / 5000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2clk,
  input  logic       ps2data,
  output logic [7:0] ps2char,
  output logic       ps2valid,
  output logic       ps2err
);

  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       brk, ext, shift;
  logic [7:0] ascii;
  logic       is_shift;

  ps2kbd_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk        (clk),
    .reset      (reset),
    .ps2clk     (ps2clk),
    .ps2data    (ps2data),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (ps2err)
  );

  always_comb begin
    ascii    = scan_to_ascii(rx_byte, shift);
    is_shift = (rx_byte == SC_LSHIFT) || (rx_byte == SC_RSHIFT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ps2char  <= 8'h00;
      ps2valid <= 1'b0;
      brk      <= 1'b0;
      ext      <= 1'b0;
      shift    <= 1'b0;
    end else begin
      ps2valid <= 1'b0;
      if (byte_valid) begin
        if (rx_byte == SC_BREAK) begin
          brk <= 1'b1;
        end else if (rx_byte == SC_EXT) begin
          ext <= 1'b1;
        end else if (brk) begin
          brk <= 1'b0;
          ext <= 1'b0;
          if (is_shift) shift <= 1'b0;
        end else if (ext) begin
          ext <= 1'b0;  // extended keys are swallowed
        end else if (is_shift) begin
          shift <= 1'b1;
        end else if (ascii != 8'h00) begin
          ps2char  <= ascii;
          ps2valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2kbd.sv
// Directed bench for ps2kbd: bit-banged PS/2 frames, pulse counters, immediate-assertion checks.
`timescale 1ns/1ps
module tb_ps2kbd;

  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2clk;
  logic       ps2data;
  logic [7:0] ps2char;
  logic       ps2valid;
  logic       ps2err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int vcnt     = 0;
  int ecnt     = 0;
  int err_cyc  = 0;
  int last_fall = 0;

  ps2kbd dut (
    .clk      (clk),
    .reset    (reset),
    .ps2clk   (ps2clk),
    .ps2data  (ps2data),
    .ps2char  (ps2char),
    .ps2valid (ps2valid),
    .ps2err   (ps2err)
  );

  always #20 clk = ~clk;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (ps2valid) vcnt <= vcnt + 1;
    if (ps2err) begin
      ecnt    <= ecnt + 1;
      err_cyc <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    ps2data = b;
    repeat (HALF) @(negedge clk);
    ps2clk = 1'b0;
    last_fall = cyc;
    repeat (HALF) @(negedge clk);
    ps2clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input logic bad_par, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, (~^code) ^ bad_par, code, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(fr[i]);
    repeat (30) @(negedge clk);
    ps2data = 1'b1;
  endtask

  task automatic send(input logic [7:0] code);
    send_frame(code, 1'b0, 11);
  endtask

  int v0, e0;

  initial begin
    reset   = 1'b1;
    ps2clk  = 1'b1;
    ps2data = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_char", 32'(ps2char), 32'h00);
    chk("reset_valid", 32'(ps2valid), 32'h0);
    chk("reset_err", 32'(ps2err), 32'h0);

    // 0x1C with a hand-driven stop bit to pin down the 2-cycle latency
    v0 = vcnt; e0 = ecnt;
    send_frame(8'h1C, 1'b0, 10);
    @(negedge clk);
    ps2data = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2clk = 1'b0;
    repeat (3) @(negedge clk);
    chk("lat_early", 32'(ps2valid), 32'h0);
    @(negedge clk);
    chk("lat_valid", 32'(ps2valid), 32'h1);
    chk("lat_char_a", 32'(ps2char), 32'h61);
    @(negedge clk);
    chk("lat_width", 32'(ps2valid), 32'h0);
    repeat (HALF) @(negedge clk);
    ps2clk = 1'b1;
    repeat (30) @(negedge clk);
    chk("a_pulses", 32'(vcnt - v0), 32'd1);
    chk("a_err", 32'(ecnt - e0), 32'd0);

    // shift make, 'A', releases, then 'a'
    v0 = vcnt;
    send(8'h12); send(8'h1C);
    chk("shift_A", 32'(ps2char), 32'h41);
    send(8'hF0); send(8'h1C);
    chk("break_no_pulse", 32'(vcnt - v0), 32'd1);
    send(8'hF0); send(8'h12); send(8'h1C);
    chk("unshift_a", 32'(ps2char), 32'h61);
    chk("shift_seq_pulses", 32'(vcnt - v0), 32'd2);

    // bad parity
    v0 = vcnt; e0 = ecnt;
    send_frame(8'h16, 1'b1, 11);
    chk("par_err", 32'(ecnt - e0), 32'd1);
    chk("par_no_valid", 32'(vcnt - v0), 32'd0);
    chk("par_char_hold", 32'(ps2char), 32'h61);
    send(8'h16);
    chk("digit_1", 32'(ps2char), 32'h31);

    // timeout after 5 bits
    v0 = vcnt; e0 = ecnt;
    send_frame(8'h29, 1'b0, 5);
    repeat (6000) @(negedge clk);
    chk("to_err", 32'(ecnt - e0), 32'd1);
    chk("to_no_valid", 32'(vcnt - v0), 32'd0);
    chk("to_timing", 32'((err_cyc - last_fall >= 4998) && (err_cyc - last_fall <= 5008)), 32'd1);
    e0 = ecnt;
    send(8'h29);
    chk("to_space", 32'(ps2char), 32'h20);
    chk("to_recover_err", 32'(ecnt - e0), 32'd0);

    // extended key swallowed, then Enter, then unmapped code
    v0 = vcnt;
    send(8'hE0); send(8'h75);
    chk("ext_no_pulse", 32'(vcnt - v0), 32'd0);
    send(8'h5A);
    chk("enter", 32'(ps2char), 32'h0D);
    send(8'h05);
    chk("unmapped", 32'(vcnt - v0), 32'd1);
    chk("unmapped_hold", 32'(ps2char), 32'h0D);

    // spurious edge with data high must not start a frame
    e0 = ecnt;
    send_bit(1'b1);
    send(8'h4D);
    chk("start_ignored_p", 32'(ps2char), 32'h70);
    chk("start_ignored_err", 32'(ecnt - e0), 32'd0);

    // shifted digit and right shift
    send(8'h59); send(8'h16);
    chk("rshift_bang", 32'(ps2char), 32'h21);
    send(8'hF0); send(8'h59); send(8'h5D);
    chk("backslash", 32'(ps2char), 32'h5C);

    // reset mid-frame while shift held
    send(8'h12);
    e0 = ecnt; v0 = vcnt;
    send_frame(8'h45, 1'b0, 5);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_char", 32'(ps2char), 32'h00);
    send(8'h45);
    chk("rst_mid_zero", 32'(ps2char), 32'h30);
    chk("rst_mid_err", 32'(ecnt - e0), 32'd0);
    chk("rst_mid_pulses", 32'(vcnt - v0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2kbd.md
Name: ps2kbd

Overview:
- PS/2 keyboard receiver for the terminal top level.
- Synchronises the keyboard clock and data lines (driven from the USB D+/D- pins) and deserialises 11-bit PS/2 frames.
- Decodes set-2 make/break scan codes, tracks Shift, and emits one ASCII character per key press with a single-cycle valid strobe.
- Runs in the 25 MHz pixel/system clock domain.

Parameters:
- CLK_HZ, 25000000, system clock frequency; used only to derive TIMEOUT_CYCLES.
- TIMEOUT_CYCLES, 5000, clock cycles (200 us) with no PS/2 falling edge before a partial frame is abandoned.

Ports:
- clk  input  1  system clock, 25 MHz.
- reset  input  1  synchronous reset, active-high.
- ps2clk  input  1  raw PS/2 clock, asynchronous, idles high.
- ps2data  input  1  raw PS/2 data, asynchronous, idles high.
- ps2char  output  8  last decoded ASCII character; holds until the next valid character.
- ps2valid  output  1  one-cycle pulse when ps2char is updated.
- ps2err  output  1  one-cycle pulse on a framing, parity or timeout error.

Behaviour:
- Reset: one clk cycle of reset gives these values.
  - ps2char=0x00, ps2valid=0, ps2err=0.
  - Synchroniser and edge-history flops = 1.
  - Bit counter = 0; shift, break and extended flags = 0; timeout counter = 0.
  - Reset during a frame discards that frame; no outputs pulse.
- Synchronisation: two flip-flops on each of ps2clk and ps2data. A falling edge is when the previous synced clock = 1 and the current synced clock = 0. Data is sampled at that edge.
- Frame format: start(0), 8 data bits LSB first, odd parity, stop(1). The bit counter runs 0..10.
- Start check: if bit 0 samples 1, the edge is ignored and the counter stays 0. No error is raised.
- Frame completion: on the 11th edge, check that XOR(data, parity) = 1 and stop = 1.
  - Pass: the byte goes to the decoder.
  - Fail: ps2err pulses, the byte is discarded, and the counter returns to 0.
- Timeout: the counter clears on every falling edge and increments while the bit counter is nonzero. When it reaches TIMEOUT_CYCLES, the bit counter returns to 0 and ps2err pulses. Timeout does not count in idle.
- Decoder rules, applied to each received byte (one clock after frame completion):
  - 0xF0: set break; no output.
  - 0xE0: set extended; no output.
  - Byte while break=1: clear break and extended. If the code is 0x12 or 0x59, clear shift. No output.
  - Byte while extended=1 (make): clear extended; no output. Extended keys are unsupported.
  - Make 0x12 or 0x59: set shift; no output.
  - Any other make: look up the ASCII value. If it is nonzero, load ps2char and pulse ps2valid. Unmapped codes produce nothing.
- Latency: ps2valid is high exactly 2 clk cycles after the cycle in which the synced stop-bit falling edge is detected. ps2char is valid in the same cycle.
- Translation table (unshifted / shifted):
  - Letters: 1C a, 32 b, 21 c, 23 d, 24 e, 2B f, 34 g, 33 h, 43 i, 3B j, 42 k, 4B l, 3A m, 31 n, 44 o, 4D p, 15 q, 2D r, 1B s, 2C t, 3C u, 2A v, 1D w, 22 x, 35 y, 1A z. Shift gives uppercase.
  - Digits: 45 0/), 16 1/!, 1E 2/@, 26 3/#, 25 4/$, 2E 5/%, 36 6/^, 3D 7/&, 3E 8/*, 46 9/(.
  - Punctuation: 4E -/_, 55 =/+, 41 ,/<, 49 ./>, 4A //?, 4C ;/:, 52 '/", 54 [/{, 5B ]/}, 5D \/|, 0E `/~.
  - Control keys, same value with or without shift: 29 space 0x20, 5A 0x0D, 66 0x08, 0D 0x09, 76 0x1B.
- Simultaneous events: a frame completion and a timeout expiry in the same cycle cannot both occur, because a falling edge clears the timeout. Error takes priority over decode.

Decomposition:
- Package ps2kbd_pkg holds:
  - constants SC_BREAK=0xF0, SC_EXT=0xE0, SC_LSHIFT=0x12, SC_RSHIFT=0x59;
  - the default TIMEOUT_CYCLES;
  - a function translating (scan code, shift) to ASCII, returning 0 when unmapped.
- One sub-module, ps2kbd_rx: synchroniser, edge detect, shift register, parity/stop check, timeout. Outputs are byte, byte_valid and frame_err.
- The decoder and flags live in ps2kbd.

Test Plan:
- Send frame 0x1C (correct odd parity) -> ps2valid pulses once, ps2char=0x61 ('a'), ps2err=0.
- Send 0x12, 0x1C, 0xF0, 0x1C, 0xF0, 0x12, 0x1C -> exactly two ps2valid pulses, ps2char=0x41 then 0x61; the break sequences produce no pulse.
- Send 0x16 with a bad parity bit -> ps2err pulses, no ps2valid, ps2char unchanged. Then send a valid 0x16 -> ps2char=0x31.
- Send 5 bits, then hold ps2clk high for 6000 cycles -> ps2err pulses at 5000 cycles. A following full 0x29 frame -> ps2char=0x20.
- Send 0xE0, 0x75, then 0x5A -> 0xE0 and 0x75 produce no pulse; 0x5A gives ps2char=0x0D. Also send unmapped 0x05 -> no pulse.
- Assert reset for one cycle mid-frame (after 4 bits), then send 0x45 -> no error; ps2char=0x30; shift flag cleared.
